transport_serializer: RTL and testbench

TRANSPORT_SERIALIZER -- requirements
Module: transport_serializer

---
 rtl/transport_pkg.sv | 19 +
 rtl/transport_fifo.sv | 57 +++++
 rtl/transport_serializer.sv | 145 ++++++++++++++
 tb/tb_transport_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/transport_pkg.sv
// rtl/transport_pkg.sv - shared types and constants for the transport serializer
package transport_pkg;

  localparam int DATA_W = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/transport_fifo.sv
// rtl/transport_fifo.sv - synchronous byte FIFO with occupancy-count full/empty
import transport_pkg::*;

module transport_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transport_serializer.sv
// rtl/transport_serializer.sv - buffered 8N1 serializer with drop accounting
import transport_pkg::*;

module transport_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr_ovf,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  tx_state_t         state_q, state_n;
  logic [CW-1:0]     baud_q, baud_n;
  logic [2:0]        bit_q, bit_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic              tx_q, tx_n;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic              baud_last;
  logic              drop;

  assign in_ready  = !full;
  assign drop      = in_valid && !in_ready;
  assign baud_last = (baud_q == BAUD_LAST);
  assign busy      = (state_q != ST_IDLE);
  assign tx        = tx_q;

  transport_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      tx_q    <= tx_n;
    end
  end

  // tx_n is the line level for the cycle after this edge, keeping tx registered.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          state_n = ST_START;
          baud_n  = '0;
          tx_n    = START_BIT;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_n = ST_DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg_q[0];
        end else begin
          baud_n = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = STOP_BIT;
          end else begin
            bit_n = bit_q + 3'd1;
            tx_n  = shreg_q[bit_q + 3'd1];
          end
        end else begin
          baud_n = baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            state_n = ST_START;
            tx_n    = START_BIT;
          end else begin
            state_n = ST_IDLE;
            tx_n    = STOP_BIT;
          end
        end else begin
          baud_n = baud_q + BAUD_ONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clr_ovf ? 8'd1 : sat_inc8(drop_cnt);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_transport_serializer.sv
// tb/tb_transport_serializer.sv - directed self-checking bench for transport_serializer
module tb_transport_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks;
  int failures;

  logic rec_en;
  logic txq[$];

  transport_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clr_ovf  (clr_ovf),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rec_en) txq.push_back(tx);

  // Called at the negedge of frame cycle 0; returns at the negedge after cycle 39.
  task automatic expect_frame(input logic [7:0] b);
    logic e;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = i / 4;
      if (k == 0) e = 1'b0;
      else if (k == 9) e = 1'b1;
      else e = b[k-1];
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL frame_tx byte=%02h cycle=%0d got=%b exp=%b", b, i, tx, e);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL frame_busy byte=%02h cycle=%0d got=%b exp=1", b, i, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout got busy=%b exp=0", name, busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({tx, busy, in_ready, overflow, drop_cnt} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_outputs got tx=%b busy=%b rdy=%b ovf=%b cnt=%0d exp 1 0 1 0 0",
               tx, busy, in_ready, overflow, drop_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    in_data = 8'hA5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got busy=%b tx=%b exp busy=0 tx=1", busy, tx);
    end
    @(negedge clk);
    expect_frame(8'hA5);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL single_end got busy=%b tx=%b exp busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_back_to_back;
    in_data = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    expect_frame(8'h00);
    expect_frame(8'hFF);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end got busy=%b tx=%b exp busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_overflow;
    int i;
    int nf;
    logic [7:0] b;
    txq.delete();
    rec_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_data = 8'(j); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (drop_cnt !== 8'd5 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_count got cnt=%0d ovf=%b exp cnt=5 ovf=1", drop_cnt, overflow);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ready got %b exp 0", in_ready);
    end
    wait_idle("ovf");
    rec_en = 1'b0;
    i = 0; nf = 0;
    while (i + 39 < txq.size()) begin
      if (txq[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txq[i + 4 * (k + 1)];
        checks++;
        if (b !== 8'(nf) || txq[i + 36] !== 1'b1) begin
          failures++;
          $display("FAIL ovf_order frame=%0d got=%02h stop=%b exp=%02h stop=1", nf, b, txq[i + 36], 8'(nf));
        end
        nf++;
        i += 40;
      end else begin
        i++;
      end
    end
    checks++;
    if (nf != 5) begin
      failures++;
      $display("FAIL ovf_frames got %0d exp 5", nf);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got cnt=%0d ovf=%b exp 0 0", drop_cnt, overflow);
    end
  endtask

  task automatic test_saturate_and_clear;
    int n;
    in_data = 8'h77; in_valid = 1'b1;
    repeat (320) @(negedge clk);
    checks++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL sat_count got cnt=%0d ovf=%b exp 255 1", drop_cnt, overflow);
    end
    n = 0;
    while (in_ready !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_hold got %0d exp 255", drop_cnt);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL sat_full got rdy=%b exp 0", in_ready);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0; in_valid = 1'b0;
    checks++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL clr_vs_drop got cnt=%0d ovf=%b exp 1 1", drop_cnt, overflow);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear got cnt=%0d ovf=%b exp 0 0", drop_cnt, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    in_data = 8'h5A; in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got %b exp 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_abort got tx=%b busy=%b rdy=%b exp 1 0 1", tx, busy, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL mid_flushed got busy=%b tx=%b exp 0 1", busy, tx);
    end
    in_data = 8'h3C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    expect_frame(8'h3C);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      failures++;
      $display("FAIL mid_after got busy=%b tx=%b exp 0 1", busy, tx);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; clr_ovf = 1'b0; rec_en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_saturate_and_clear();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
